uart_cmd_decoder: RTL and testbench
===================================

// Module: uart_cmd_decoder
// PURPOSE
//  Target-side UART debug command engine: parses byte commands from UART_RX, drives the
//  CPU/PPU memory bus, and returns read data through UART_TX. Sits inside the
//  ppu/cpu top level between the UART pair and the bus arbiter. Owns the CPU halt flag.
//  Commands: 0x00 HALT, 0x01 RESUME, 0x02 WRITE (addr_hi, addr_lo, data), 0x03 READ (addr_hi, addr_lo).
//  A READ returns exactly one byte.
// PARAMETERS
//  RD_LATENCY      1      cycles from bus_re pulse to bus_rdata valid (>=1)
//  TIMEOUT_CYCLES  20000  idle cycles allowed between bytes of one command (about 9 byte-times at 25MHz/115200)
//  NOHALT_RD_BYTE  8'hEE  byte returned for a READ issued while the CPU is not halted
// PORTS
//  clk        in   1   system clock (25MHz)
//  rst        in   1   asynchronous reset, active-high
//  rx_valid   in   1   one-cycle strobe from UART_RX: rx_data is valid
//  rx_data    in   8   received byte
//  tx_start   out  1   one-cycle strobe to UART_TX
//  tx_data    out  8   byte to transmit; held stable from the tx_start cycle until tx_done
//  tx_active  in   1   UART_TX is shifting a byte
//  tx_done    in   1   one-cycle strobe: UART_TX has finished the byte
//  bus_addr   out  16  bus address; held stable through the whole access
//  bus_wdata  out  8   write data
//  bus_we     out  1   one-cycle write strobe
//  bus_re     out  1   one-cycle read strobe
//  bus_rdata  in   8   read data, valid RD_LATENCY cycles after bus_re
//  cpu_halt   out  1   1 = CPU stalled and bus granted to this block
//  busy       out  1   1 whenever state != IDLE
//  err_count  out  8   saturating count of protocol errors
// BEHAVIOUR
//  Reset values: all outputs 0, including cpu_halt. State = IDLE. Timeout counter = 0.
//  States: IDLE, ADDR_HI, ADDR_LO, WDATA, BUS_WR, BUS_RD, RD_WAIT, TX_REQ, TX_WAIT.
//  IDLE, on rx_valid, by opcode:
//    0x00 -> cpu_halt <= 1, stay IDLE.
//    0x01 -> cpu_halt <= 0, stay IDLE.
//    0x02 or 0x03 -> latch opcode, go to ADDR_HI.
//    any other value -> err_count++, stay IDLE.
//  ADDR_HI: on rx_valid, latch bus_addr[15:8], go to ADDR_LO.
//  ADDR_LO: on rx_valid, latch bus_addr[7:0].
//    Opcode WRITE -> WDATA.
//    Opcode READ -> BUS_RD if halted, else load NOHALT_RD_BYTE into tx_data, err_count++, go to TX_REQ.
//  WDATA: on rx_valid, latch bus_wdata.
//    If halted -> BUS_WR.
//    If not halted -> drop the write, err_count++, go to IDLE.
//  BUS_WR: bus_we = 1 for exactly one cycle, then IDLE. Write latency is 2 cycles from the last rx_valid.
//  BUS_RD: bus_re = 1 for exactly one cycle, then RD_WAIT.
//    Exactly one pulse per command, because PPU $2002/$2007 reads have side effects.
//  RD_WAIT: count RD_LATENCY cycles, capture bus_rdata into tx_data, go to TX_REQ.
//  TX_REQ: when tx_active == 0, pulse tx_start for one cycle, go to TX_WAIT.
//  TX_WAIT: on tx_done, go to IDLE.
//  Timeout: the counter resets on every rx_valid and increments while in ADDR_HI, ADDR_LO or WDATA.
//    When it reaches TIMEOUT_CYCLES: go to IDLE, err_count++, no bus access.
//  rx_valid arriving in BUS_WR, BUS_RD, RD_WAIT, TX_REQ or TX_WAIT: byte dropped, err_count++.
//  Simultaneous rx_valid and timeout expiry in the same cycle: the byte wins and the counter clears.
//  err_count saturates at 8'hFF and never wraps.
//  cpu_halt is changed only by HALT/RESUME and is never cleared mid-command.
//  Async rst mid-command or mid-TX: immediate return to IDLE, strobes deasserted, cpu_halt = 0.
//    Partial UART frames are the UART modules' concern.
//  bus_addr and bus_wdata keep their last values while IDLE (no glitch to 0).
// STRUCTURE
//  Package uart_cmd_pkg holds:
//    opcode localparams CMD_HALT=8'h00, CMD_RESUME=8'h01, CMD_WRITE=8'h02, CMD_READ=8'h03;
//    typedef enum logic [3:0] cmd_state_t for the nine states.
//  One sub-module, cmd_timeout_timer:
//    inputs clear, enable; output expired;
//    counter width $clog2(TIMEOUT_CYCLES+1).
//  Everything else is a single FSM plus datapath registers in this module.
// TESTING
//  Directed scenarios (bench reuses the UART_TX/UART_RX pair and a behavioural 64KB memory model):
//  1. rst, then 00 -> cpu_halt=1; 02 20 06 3F -> single bus_we, bus_addr=16'h2006, bus_wdata=8'h3F.
//  2. Halted; mem[16'h0300]=8'hA5; send 03 03 00 -> single bus_re pulse; UART returns 8'hA5; busy falls after tx_done.
//  3. Not halted: 02 12 34 56 -> no bus_we, err_count=1.
//     Then 03 12 34 -> no bus_re, reply 8'hEE, err_count=2.
//  4. Send 02 20 then nothing for TIMEOUT_CYCLES -> IDLE, err_count+1.
//     Then 00 01 -> cpu_halt pulses 1 then 0, parser resynchronised.
//  5. Invalid opcode 7F -> err_count+1, no bus strobes.
//     A byte sent during TX_WAIT of a READ -> dropped, err_count+1, read reply intact.
//  6. Assert rst during RD_WAIT -> all outputs 0 next cycle, no tx_start.
//     Drive 300 bad opcodes -> err_count holds at 8'hFF.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - opcodes, FSM state type and helpers for the UART debug command engine
package uart_cmd_pkg;

    localparam logic [7:0] CMD_HALT   = 8'h00;
    localparam logic [7:0] CMD_RESUME = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WDATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_WAIT,
        ST_TX_REQ,
        ST_TX_WAIT
    } cmd_state_t;

    // Error counter increment that sticks at 8'hFF.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// rtl/cmd_timeout_timer.sv - inter-byte idle timer for the UART command parser
// Ports: clk, rst (async, active-high); clear zeroes the count; enable advances it;
//        expired is high while the count equals TIMEOUT_CYCLES.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART byte command engine driving the CPU/PPU memory bus
// Ports: clk, rst (async, active-high); rx_valid/rx_data from UART_RX;
//        tx_start/tx_data to UART_TX with tx_active/tx_done back; bus_addr/bus_wdata/
//        bus_we/bus_re/bus_rdata memory bus; cpu_halt, busy, err_count status.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int         RD_LATENCY     = 1,
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter logic [7:0] NOHALT_RD_BYTE = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [7:0]  bus_rdata,
    output logic        cpu_halt,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int RW = $clog2(RD_LATENCY + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(RD_LATENCY);

    cmd_state_t    state, state_n;
    logic [7:0]    opcode, opcode_n;
    logic [15:0]   addr_n;
    logic [7:0]    wdata_n;
    logic [7:0]    txd_n;
    logic          halt_n;
    logic          err_inc;
    logic [RW-1:0] rd_cnt, rd_cnt_n;
    logic          in_arg_state;
    logic          expired;

    assign in_arg_state = (state == ST_ADDR_HI) || (state == ST_ADDR_LO) || (state == ST_WDATA);
    assign busy         = (state != ST_IDLE);

    // Held at zero outside the argument states so every command starts a fresh window.
    cmd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid || !in_arg_state),
        .enable  (in_arg_state),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            opcode    <= 8'h00;
            bus_addr  <= 16'h0000;
            bus_wdata <= 8'h00;
            tx_data   <= 8'h00;
            cpu_halt  <= 1'b0;
            err_count <= 8'h00;
            rd_cnt    <= '0;
        end else begin
            state     <= state_n;
            opcode    <= opcode_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
            tx_data   <= txd_n;
            cpu_halt  <= halt_n;
            err_count <= err_inc ? sat_inc8(err_count) : err_count;
            rd_cnt    <= rd_cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        opcode_n = opcode;
        addr_n   = bus_addr;
        wdata_n  = bus_wdata;
        txd_n    = tx_data;
        halt_n   = cpu_halt;
        rd_cnt_n = rd_cnt;
        err_inc  = 1'b0;
        bus_we   = 1'b0;
        bus_re   = 1'b0;
        tx_start = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_HALT:   halt_n = 1'b1;
                        CMD_RESUME: halt_n = 1'b0;
                        CMD_WRITE, CMD_READ: begin
                            opcode_n = rx_data;
                            state_n  = ST_ADDR_HI;
                        end
                        default:    err_inc = 1'b1;
                    endcase
                end
            end
            // A byte arriving in the expiry cycle takes priority over the timeout.
            ST_ADDR_HI: begin
                if (rx_valid) begin
                    addr_n[15:8] = rx_data;
                    state_n      = ST_ADDR_LO;
                end else if (expired) begin
                    err_inc = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_ADDR_LO: begin
                if (rx_valid) begin
                    addr_n[7:0] = rx_data;
                    if (opcode == CMD_WRITE) begin
                        state_n = ST_WDATA;
                    end else if (cpu_halt) begin
                        state_n = ST_BUS_RD;
                    end else begin
                        txd_n   = NOHALT_RD_BYTE;
                        err_inc = 1'b1;
                        state_n = ST_TX_REQ;
                    end
                end else if (expired) begin
                    err_inc = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    wdata_n = rx_data;
                    if (cpu_halt) begin
                        state_n = ST_BUS_WR;
                    end else begin
                        err_inc = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else if (expired) begin
                    err_inc = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_BUS_WR: begin
                bus_we  = 1'b1;
                state_n = ST_IDLE;
            end
            // Single read strobe per command: PPU status/data reads have side effects.
            ST_BUS_RD: begin
                bus_re   = 1'b1;
                rd_cnt_n = RW'(1);
                state_n  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (rd_cnt == RD_LAST) begin
                    txd_n   = bus_rdata;
                    state_n = ST_TX_REQ;
                end else begin
                    rd_cnt_n = rd_cnt + 1'b1;
                end
            end
            ST_TX_REQ: begin
                if (!tx_active) begin
                    tx_start = 1'b1;
                    state_n  = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (tx_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // The engine cannot accept a new byte while it owns the bus or the transmitter.
        if (rx_valid && (state == ST_BUS_WR || state == ST_BUS_RD || state == ST_RD_WAIT ||
                         state == ST_TX_REQ || state == ST_TX_WAIT)) begin
            err_inc = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

    localparam int TO  = 300;
    localparam int RDL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  bus_rdata;
    logic        cpu_halt;
    logic        busy;
    logic [7:0]  err_count;

    uart_cmd_decoder #(.RD_LATENCY(RDL), .TIMEOUT_CYCLES(TO), .NOHALT_RD_BYTE(8'hEE)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .cpu_halt(cpu_halt), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Behavioural 64KB memory with a RDL-cycle read pipeline.
    logic [7:0] mem [0:65535];
    logic [7:0] p1 = 8'h00, p2 = 8'h00, p3 = 8'h00;
    assign bus_rdata = p3;
    always @(posedge clk) begin
        if (rst) mem[16'h0300] <= 8'hA5;
        else if (bus_we) mem[bus_addr] <= bus_wdata;
        p1 <= mem[bus_addr];
        p2 <= p1;
        p3 <= p2;
    end

    // Transmitter model: 8 busy cycles then a done strobe.
    int tx_left = 0;
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (tx_start) begin
            tx_active <= 1'b1;
            tx_left   <= 8;
        end else if (tx_active) begin
            if (tx_left == 1) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
            end
            tx_left <= tx_left - 1;
        end
    end

    int we_n = 0, re_n = 0, tx_n = 0;
    logic [7:0] last_tx = 8'h00;
    always @(posedge clk) begin
        if (bus_we) we_n <= we_n + 1;
        if (bus_re) re_n <= re_n + 1;
        if (tx_start) begin
            tx_n    <= tx_n + 1;
            last_tx <= tx_data;
        end
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        check("idle_reached", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic        halt;
        logic [7:0]  err;
        int          we;
        int          re;
        int          tx;
        logic [7:0]  txb;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int we0, re0, tx0;
        logic [7:0] err0;

        vecs[0] = '{32'h00000000, 1, 1'b1, 8'd0, 0, 0, 0, 8'h00, 16'h0000, 8'h00};
        vecs[1] = '{32'h0220063F, 4, 1'b1, 8'd0, 1, 0, 0, 8'h00, 16'h2006, 8'h3F};
        vecs[2] = '{32'h03030000, 3, 1'b1, 8'd0, 0, 1, 1, 8'hA5, 16'h0300, 8'h3F};
        vecs[3] = '{32'h01000000, 1, 1'b0, 8'd0, 0, 0, 0, 8'h00, 16'h0300, 8'h3F};
        vecs[4] = '{32'h02123456, 4, 1'b0, 8'd1, 0, 0, 0, 8'h00, 16'h1234, 8'h56};
        vecs[5] = '{32'h03123400, 3, 1'b0, 8'd2, 0, 0, 1, 8'hEE, 16'h1234, 8'h56};
        vecs[6] = '{32'h7F000000, 1, 1'b0, 8'd3, 0, 0, 0, 8'h00, 16'h1234, 8'h56};
        vecs[7] = '{32'h00000000, 1, 1'b1, 8'd3, 0, 0, 0, 8'h00, 16'h1234, 8'h56};
        vecs[8] = '{32'h03200600, 3, 1'b1, 8'd3, 0, 1, 1, 8'h3F, 16'h2006, 8'h56};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {tx_start, bus_we, bus_re, cpu_halt, busy, err_count, bus_addr, bus_wdata, tx_data}, 64'd0);

        for (int v = 0; v < 9; v++) begin
            we0 = we_n; re0 = re_n; tx0 = tx_n;
            for (int k = 0; k < vecs[v].n; k++) begin
                send_byte(vecs[v].bytes[31-8*k -: 8]);
                repeat (2) @(negedge clk);
            end
            wait_idle();
            check($sformatf("v%0d_halt", v), cpu_halt, vecs[v].halt);
            check($sformatf("v%0d_err", v), err_count, vecs[v].err);
            check($sformatf("v%0d_we", v), we_n - we0, vecs[v].we);
            check($sformatf("v%0d_re", v), re_n - re0, vecs[v].re);
            check($sformatf("v%0d_tx", v), tx_n - tx0, vecs[v].tx);
            check($sformatf("v%0d_addr", v), bus_addr, vecs[v].addr);
            check($sformatf("v%0d_wdata", v), bus_wdata, vecs[v].wdata);
            if (vecs[v].tx != 0) check($sformatf("v%0d_txbyte", v), last_tx, vecs[v].txb);
        end

        // Inter-byte timeout: 02 20 then silence.
        err0 = err_count; we0 = we_n;
        send_byte(8'h02);
        send_byte(8'h20);
        repeat (TO - 10) @(negedge clk);
        check("timeout_not_yet", busy, 1);
        repeat (20) @(negedge clk);
        check("timeout_idle", busy, 0);
        check("timeout_err", err_count, err0 + 8'd1);
        check("timeout_no_we", we_n - we0, 0);
        send_byte(8'h00);
        @(negedge clk);
        check("resync_halt", cpu_halt, 1);
        send_byte(8'h01);
        @(negedge clk);
        check("resync_resume", cpu_halt, 0);
        send_byte(8'h00);
        @(negedge clk);

        // Byte arriving while the read reply is being shifted out.
        err0 = err_count; re0 = re_n; tx0 = tx_n;
        send_byte(8'h03);
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 60 && !tx_active; i++) @(negedge clk);
        check("txwait_reached", tx_active, 1);
        send_byte(8'h55);
        wait_idle();
        check("txwait_err", err_count, err0 + 8'd1);
        check("txwait_re", re_n - re0, 1);
        check("txwait_tx", tx_n - tx0, 1);
        check("txwait_byte", last_tx, 8'hA5);

        // Reset in the middle of the read latency window.
        send_byte(8'h03);
        send_byte(8'h03);
        send_byte(8'h00);
        check("rd_strobe", bus_re, 1);
        @(negedge clk);
        tx0 = tx_n;
        rst = 1'b1;
        #1;
        check("midrd_reset_outputs",
              {tx_start, bus_we, bus_re, cpu_halt, busy, err_count, bus_addr, bus_wdata, tx_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrd_no_tx", tx_n - tx0, 0);
        check("midrd_idle", busy, 0);

        // Error counter saturation.
        for (int i = 0; i < 254; i++) send_byte(8'h7F);
        @(negedge clk);
        check("err_fe", err_count, 8'hFE);
        for (int i = 0; i < 46; i++) send_byte(8'h7F);
        @(negedge clk);
        check("err_sat", err_count, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
